matrix_scoreboard: RTL and testbench
====================================

# matrix_scoreboard

Register-hazard scoreboard and issue gate for the matrix coprocessor. It sits between the instruction decoder and the functional units: systolic array, LSU and RF-write unit. It admits an instruction only when its functional unit is free and no RAW, WAW or WAR hazard exists on the matrix registers. It holds per-FU bookkeeping until each unit reports its reads done and its write done.

## Interface
Parameters:
- N_REGS, 8, number of matrix registers
- NUM_EXEC_UNITS, 3, number of functional units, indexed as execution_units_t
- MAX_NUM_READ_OPERANDS, 3, source-operand slots per instruction
- ID_WIDTH, xif_pkg::X_ID_WIDTH, instruction ID width

Ports (RW = $clog2(N_REGS), FW = $clog2(NUM_EXEC_UNITS)):
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  decoder offers an instruction
- issue_ready_o  out  1  scoreboard accepts it; issue happens when valid & ready
- issue_fu_i  in  FW  target unit
- issue_rs_i  in  MAX_NUM_READ_OPERANDS×RW  source registers
- issue_rs_valid_i  in  MAX_NUM_READ_OPERANDS  per-source enable
- issue_rd_i  in  RW  destination register
- issue_rd_valid_i  in  1  destination enable
- issue_id_i  in  ID_WIDTH  instruction ID
- rd_done_i  in  NUM_EXEC_UNITS  per-FU pulse: all source reads finished
- wr_done_i  in  NUM_EXEC_UNITS  per-FU pulse: destination written
- fu_busy_o  out  NUM_EXEC_UNITS  per-FU slot occupied
- fu_id_o  out  NUM_EXEC_UNITS×ID_WIDTH  ID held in each slot
- wr_pending_o  out  N_REGS  register has an outstanding writer
- idle_o  out  1  all slots free

## Operation
- State:
  - Per register: wr_pend bit and rd_cnt, width $clog2(NUM_EXEC_UNITS+1).
  - Per FU slot: src mask (N_REGS bits), rd, rd_valid, id, and an FSM.
- FSM per FU:
  - IDLE --issue--> EXEC
  - EXEC --rd_done--> WAIT_WR
  - EXEC --wr_done (with or without rd_done)--> IDLE, releasing both reads and the write
  - WAIT_WR --wr_done--> IDLE
  - rd_done in WAIT_WR or IDLE is ignored; wr_done in IDLE is ignored.
- Hazard check, combinational on issue fields:
  - fu_free: slot of issue_fu_i is IDLE.
  - RAW: any enabled rs has wr_pend set.
  - WAW: rd enabled and wr_pend[rd] set.
  - WAR: rd enabled and rd_cnt[rd] != 0.
  - issue_ready_o = fu_free & !RAW & !WAW & !WAR. It does not depend on issue_valid_i.
- On issue:
  - wr_pend[rd] is set if rd is enabled.
  - rd_cnt is incremented once per distinct enabled source register; duplicate sources are merged into a one-hot-OR mask.
  - Slot is loaded.
- Self-dependence:
  - An instruction reading and writing the same register is legal. Its own reads are not counted against its own WAR check, because the check uses pre-issue state.
- Release:
  - Reads: decrement rd_cnt for every register in the slot's src mask.
  - Write: clear wr_pend[rd].
  - Releases from several FUs in the same cycle combine per register (counter minus number of releasing slots).
  - Issue and release of the same register in one cycle: apply decrement and increment together.
- rd_cnt saturation cannot occur by construction: one slot per FU.
- Outputs:
  - wr_pending_o = wr_pend.
  - fu_busy_o = slot != IDLE.
  - idle_o = no slot busy.

## Timing
- Reset state:
  - All slots IDLE, all wr_pend = 0, all rd_cnt = 0, fu_id_o = 0.
  - Outputs under reset: issue_ready_o = 1 (all slots free, no pending hazards), fu_busy_o = 0, wr_pending_o = 0, idle_o = 1.
- Issue latency: a handshake updates state at the next clock edge. fu_busy_o and wr_pending_o rise one cycle after the handshake.
- Without the bypass, a release becomes visible to the hazard check one cycle after the done pulse. Re-issue to the freed FU or register is therefore possible at the earliest 1 cycle after the done cycle.
- Throughput: one issue per cycle when hazard-free.
- Reset mid-operation drops all slots and counters immediately (asynchronous). Done pulses arriving afterwards hit IDLE slots and are ignored.

## Configuration
- QUADRILATERO_SB_BYPASS_EN defined:
  - The hazard check and fu_free use post-release state: current state with this cycle's rd_done/wr_done releases applied.
  - Issue is allowed in the same cycle as the release.
  - This adds a done-to-ready combinational path.
- Undefined: the hazard check uses registered state only, giving one bubble cycle.

## Test plan
- After reset, issue a systolic-array op (rs = {1,2,3}, rd = 3):
  - issue_ready_o = 1 and the op is accepted.
  - Next cycle: fu_busy_o = 3'b001, wr_pending_o[3] = 1.
- RAW: with SA writing r3, offer an LSU store reading r3:
  - ready = 0 until SA wr_done.
  - Without bypass: ready = 1 one cycle after wr_done; with bypass: ready = 1 in the wr_done cycle.
- WAR: with SA reading r1 (rd_cnt[1] = 1), offer an LSU load to r1:
  - Blocked until SA rd_done, then accepted while SA stays in WAIT_WR.
- Duplicate and simultaneous releases:
  - Issue rs = {2,2,0} on the SA and an LSU store reading r2: rd_cnt[2] = 2.
  - Both FUs assert rd_done in the same cycle: rd_cnt[2] = 0 next cycle.
- wr_done without rd_done in EXEC: slot returns to IDLE, rd_cnt and wr_pend are both cleared, idle_o = 1.
- Assert rst_ni low with all three slots busy:
  - All outputs return to reset values asynchronously.
  - Done pulses after reset release have no effect.

Source files
------------

// File: rtl/matrix_scoreboard.sv
// Register-hazard scoreboard and issue gate for the matrix coprocessor (SA=0, LSU=1, RF-write=2).
// Define QUADRILATERO_SB_BYPASS_EN to let same-cycle rd_done/wr_done releases unblock issue.
module matrix_scoreboard #(
  parameter int N_REGS                = 8,
  parameter int NUM_EXEC_UNITS        = 3,
  parameter int MAX_NUM_READ_OPERANDS = 3,
  parameter int ID_WIDTH              = 4,
  localparam int RW = $clog2(N_REGS),
  localparam int FW = $clog2(NUM_EXEC_UNITS),
  localparam int CW = $clog2(NUM_EXEC_UNITS + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                issue_valid_i,
  output logic                                issue_ready_o,
  input  logic [FW-1:0]                       issue_fu_i,
  input  logic [MAX_NUM_READ_OPERANDS*RW-1:0] issue_rs_i,
  input  logic [MAX_NUM_READ_OPERANDS-1:0]    issue_rs_valid_i,
  input  logic [RW-1:0]                       issue_rd_i,
  input  logic                                issue_rd_valid_i,
  input  logic [ID_WIDTH-1:0]                 issue_id_i,
  input  logic [NUM_EXEC_UNITS-1:0]           rd_done_i,
  input  logic [NUM_EXEC_UNITS-1:0]           wr_done_i,
  output logic [NUM_EXEC_UNITS-1:0]           fu_busy_o,
  output logic [NUM_EXEC_UNITS*ID_WIDTH-1:0]  fu_id_o,
  output logic [N_REGS-1:0]                   wr_pending_o,
  output logic                                idle_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_WAIT_WR = 2'd2
  } fu_state_t;

  // Per-slot views exported from the generate blocks
  logic [N_REGS-1:0]         src_mask [NUM_EXEC_UNITS];
  logic [RW-1:0]             rd_slot  [NUM_EXEC_UNITS];
  logic [NUM_EXEC_UNITS-1:0] rd_valid_slot;
  logic [NUM_EXEC_UNITS-1:0] busy;
  logic [NUM_EXEC_UNITS-1:0] rel_rd;
  logic [NUM_EXEC_UNITS-1:0] rel_wr;
  logic [NUM_EXEC_UNITS-1:0] fu_avail;
  logic [NUM_EXEC_UNITS-1:0] slot_load;

  // Per-register bookkeeping
  logic [N_REGS-1:0] wr_pend_reg;
  logic [N_REGS-1:0] wr_pend_next;
  logic [N_REGS-1:0] wr_pend_chk;
  logic [N_REGS-1:0] wr_clr;
  logic [CW-1:0]     rd_cnt_reg  [N_REGS];
  logic [CW-1:0]     rd_cnt_next [N_REGS];
  logic [CW-1:0]     rd_cnt_chk  [N_REGS];
  logic [CW-1:0]     rd_dec      [N_REGS];

  // Issue decode
  logic [N_REGS-1:0]      rs_mask;
  logic [N_REGS-1:0]      rd_onehot;
  logic [(1<<FW)-1:0]     avail_pad;
  logic                   fu_free;
  logic                   raw_hz;
  logic                   waw_hz;
  logic                   war_hz;
  logic                   issue_fire;

  // Duplicate sources collapse into one mask bit, so each register is counted once
  always_comb begin
    rs_mask = '0;
    for (int k = 0; k < MAX_NUM_READ_OPERANDS; k++) begin
      if (issue_rs_valid_i[k]) begin
        rs_mask[issue_rs_i[k*RW +: RW]] = 1'b1;
      end
    end
  end

  assign rd_onehot = issue_rd_valid_i ? (N_REGS'(1) << issue_rd_i) : '0;

  generate
    for (genvar gi = 0; gi < NUM_EXEC_UNITS; gi++) begin : g_fu
      fu_state_t             state_reg;
      fu_state_t             state_next;
      logic [N_REGS-1:0]     src_mask_reg;
      logic [RW-1:0]         rd_reg;
      logic                  rd_valid_reg;
      logic [ID_WIDTH-1:0]   id_reg;
      logic                  busy_o_l;
      logic                  rel_rd_l;
      logic                  rel_wr_l;
      logic                  avail_l;

      assign slot_load[gi] = issue_fire && (issue_fu_i == FW'(gi));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_reg <= ST_IDLE;
        end else begin
          state_reg <= state_next;
        end
      end

      // A releasing slot may be reloaded in the same cycle when bypass is on
      always_comb begin
        state_next = state_reg;
        case (state_reg)
          ST_IDLE: begin
            state_next = ST_IDLE;
          end
          ST_EXEC: begin
            if (wr_done_i[gi]) begin
              state_next = ST_IDLE;
            end else if (rd_done_i[gi]) begin
              state_next = ST_WAIT_WR;
            end
          end
          ST_WAIT_WR: begin
            if (wr_done_i[gi]) begin
              state_next = ST_IDLE;
            end
          end
          default: state_next = ST_IDLE;
        endcase
        if (slot_load[gi]) begin
          state_next = ST_EXEC;
        end
      end

      always_comb begin
        busy_o_l = (state_reg != ST_IDLE);
        rel_rd_l = (state_reg == ST_EXEC) && (rd_done_i[gi] || wr_done_i[gi]);
        rel_wr_l = (state_reg != ST_IDLE) && wr_done_i[gi];
`ifdef QUADRILATERO_SB_BYPASS_EN
        avail_l  = !busy_o_l || rel_wr_l;
`else
        avail_l  = !busy_o_l;
`endif
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          src_mask_reg <= '0;
          rd_reg       <= '0;
          rd_valid_reg <= 1'b0;
          id_reg       <= '0;
        end else if (slot_load[gi]) begin
          src_mask_reg <= rs_mask;
          rd_reg       <= issue_rd_i;
          rd_valid_reg <= issue_rd_valid_i;
          id_reg       <= issue_id_i;
        end
      end

      assign src_mask[gi]      = src_mask_reg;
      assign rd_slot[gi]       = rd_reg;
      assign rd_valid_slot[gi] = rd_valid_reg;
      assign busy[gi]          = busy_o_l;
      assign rel_rd[gi]        = rel_rd_l;
      assign rel_wr[gi]        = rel_wr_l;
      assign fu_avail[gi]      = avail_l;
      assign fu_id_o[gi*ID_WIDTH +: ID_WIDTH] = id_reg;
    end
  endgenerate

  // Combine releases from all slots per register
  always_comb begin
    for (int r = 0; r < N_REGS; r++) begin
      rd_dec[r] = '0;
      wr_clr[r] = 1'b0;
      for (int f = 0; f < NUM_EXEC_UNITS; f++) begin
        if (rel_rd[f] && src_mask[f][r]) begin
          rd_dec[r] = rd_dec[r] + CW'(1);
        end
        if (rel_wr[f] && rd_valid_slot[f] && (rd_slot[f] == RW'(r))) begin
          wr_clr[r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < N_REGS; r++) begin
`ifdef QUADRILATERO_SB_BYPASS_EN
      rd_cnt_chk[r] = rd_cnt_reg[r] - rd_dec[r];
`else
      rd_cnt_chk[r] = rd_cnt_reg[r];
`endif
    end
`ifdef QUADRILATERO_SB_BYPASS_EN
    wr_pend_chk = wr_pend_reg & ~wr_clr;
`else
    wr_pend_chk = wr_pend_reg;
`endif
  end

  // Hazard check uses pre-issue state, so an op's own reads never block its own write
  always_comb begin
    avail_pad = '0;
    avail_pad[NUM_EXEC_UNITS-1:0] = fu_avail;
    fu_free = avail_pad[issue_fu_i];
    raw_hz  = |(rs_mask & wr_pend_chk);
    waw_hz  = issue_rd_valid_i && wr_pend_chk[issue_rd_i];
    war_hz  = issue_rd_valid_i && (rd_cnt_chk[issue_rd_i] != '0);
  end

  assign issue_ready_o = fu_free && !raw_hz && !waw_hz && !war_hz;
  assign issue_fire    = issue_valid_i && issue_ready_o;

  always_comb begin
    wr_pend_next = (wr_pend_reg & ~wr_clr) | (issue_fire ? rd_onehot : '0);
    for (int r = 0; r < N_REGS; r++) begin
      rd_cnt_next[r] = rd_cnt_reg[r] - rd_dec[r]
                       + ((issue_fire && rs_mask[r]) ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_pend_reg <= '0;
      for (int r = 0; r < N_REGS; r++) begin
        rd_cnt_reg[r] <= '0;
      end
    end else begin
      wr_pend_reg <= wr_pend_next;
      for (int r = 0; r < N_REGS; r++) begin
        rd_cnt_reg[r] <= rd_cnt_next[r];
      end
    end
  end

  assign fu_busy_o    = busy;
  assign wr_pending_o = wr_pend_reg;
  assign idle_o       = ~|busy;

endmodule

// File: tb/tb_matrix_scoreboard.sv
// Directed bench for matrix_scoreboard: issue, RAW/WAR/WAW gating, releases and async reset.
module tb_matrix_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_fu;
  logic [8:0]  issue_rs;
  logic [2:0]  issue_rs_valid;
  logic [2:0]  issue_rd;
  logic        issue_rd_valid;
  logic [3:0]  issue_id;
  logic [2:0]  rd_done;
  logic [2:0]  wr_done;
  logic [2:0]  fu_busy;
  logic [11:0] fu_id;
  logic [7:0]  wr_pending;
  logic        idle;

  int total = 0;
  int bad   = 0;
  logic bypass_en;

  matrix_scoreboard dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_fu_i       (issue_fu),
    .issue_rs_i       (issue_rs),
    .issue_rs_valid_i (issue_rs_valid),
    .issue_rd_i       (issue_rd),
    .issue_rd_valid_i (issue_rd_valid),
    .issue_id_i       (issue_id),
    .rd_done_i        (rd_done),
    .wr_done_i        (wr_done),
    .fu_busy_o        (fu_busy),
    .fu_id_o          (fu_id),
    .wr_pending_o     (wr_pending),
    .idle_o           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rs packed as {rs2, rs1, rs0}
  task automatic drive(input logic [1:0] fu, input logic [2:0] rs2, input logic [2:0] rs1,
                       input logic [2:0] rs0, input logic [2:0] rsv, input logic [2:0] rd,
                       input logic rdv, input logic [3:0] id, input logic v);
    issue_fu       = fu;
    issue_rs       = {rs2, rs1, rs0};
    issue_rs_valid = rsv;
    issue_rd       = rd;
    issue_rd_valid = rdv;
    issue_id       = id;
    issue_valid    = v;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'd0, 3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 1'b0, 4'd0, 1'b0);
    rd_done = '0; wr_done = '0;
    step(); step();
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
    total++; if (fu_busy !== 3'b000) begin bad++; $display("FAIL reset_busy: got %b want 000", fu_busy); end
    total++; if (wr_pending !== 8'h00) begin bad++; $display("FAIL reset_wrpend: got %h want 00", wr_pending); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", idle); end
    total++; if (fu_id !== 12'h000) begin bad++; $display("FAIL reset_id: got %h want 000", fu_id); end
    rst_n = 1'b1;
    step();
    $display("reset: ready=%b busy=%b wrpend=%h idle=%b", issue_ready, fu_busy, wr_pending, idle);
  endtask

  task automatic test_issue_basic();
    drive(2'd0, 3'd3, 3'd2, 3'd1, 3'b111, 3'd3, 1'b1, 4'd5, 1'b1);
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL issue_ready: got %b want 1", issue_ready); end
    total++; if (fu_busy !== 3'b000) begin bad++; $display("FAIL issue_busy_pre: got %b want 000", fu_busy); end
    step();
    issue_valid = 1'b0; #1;
    total++; if (fu_busy !== 3'b001) begin bad++; $display("FAIL issue_busy: got %b want 001", fu_busy); end
    total++; if (wr_pending !== 8'h08) begin bad++; $display("FAIL issue_wrpend: got %h want 08", wr_pending); end
    total++; if (fu_id[3:0] !== 4'd5) begin bad++; $display("FAIL issue_id: got %h want 5", fu_id[3:0]); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL issue_idle: got %b want 0", idle); end
    $display("issue SA rs={1,2,3} rd=3: busy=%b wrpend=%h id=%h", fu_busy, wr_pending, fu_id);
  endtask

  task automatic test_raw();
    // LSU store reads r3 while SA still owes the write
    drive(2'd1, 3'd0, 3'd0, 3'd3, 3'b001, 3'd0, 1'b0, 4'd6, 1'b1);
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL raw_block0: got %b want 0", issue_ready); end
    step();
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL raw_block1: got %b want 0", issue_ready); end
    total++; if (fu_busy !== 3'b001) begin bad++; $display("FAIL raw_no_issue: got %b want 001", fu_busy); end
    issue_valid = 1'b0;
    wr_done = 3'b001; #1;
    total++; if (issue_ready !== bypass_en) begin bad++; $display("FAIL raw_done_cycle: got %b want %b", issue_ready, bypass_en); end
    step();
    wr_done = 3'b000; #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL raw_after: got %b want 1", issue_ready); end
    total++; if (wr_pending !== 8'h00) begin bad++; $display("FAIL raw_wrpend: got %h want 00", wr_pending); end
    total++; if (fu_busy !== 3'b000) begin bad++; $display("FAIL raw_sa_free: got %b want 000", fu_busy); end
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0; #1;
    total++; if (fu_busy !== 3'b010) begin bad++; $display("FAIL raw_lsu_busy: got %b want 010", fu_busy); end
    $display("raw: LSU accepted after SA wr_done busy=%b", fu_busy);
    wr_done = 3'b010; step(); wr_done = 3'b000; #1;
  endtask

  task automatic test_war();
    drive(2'd0, 3'd0, 3'd0, 3'd1, 3'b001, 3'd4, 1'b1, 4'd7, 1'b1);
    step();
    // LSU load to r1 must wait for SA to finish reading r1
    drive(2'd1, 3'd0, 3'd0, 3'd0, 3'b000, 3'd1, 1'b1, 4'd8, 1'b1);
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL war_block: got %b want 0", issue_ready); end
    issue_valid = 1'b0;
    rd_done = 3'b001; #1;
    total++; if (issue_ready !== bypass_en) begin bad++; $display("FAIL war_done_cycle: got %b want %b", issue_ready, bypass_en); end
    step();
    rd_done = 3'b000; #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL war_after: got %b want 1", issue_ready); end
    total++; if (fu_busy !== 3'b001) begin bad++; $display("FAIL war_sa_waitwr: got %b want 001", fu_busy); end
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0; #1;
    total++; if (fu_busy !== 3'b011) begin bad++; $display("FAIL war_lsu_busy: got %b want 011", fu_busy); end
    total++; if (wr_pending !== 8'h12) begin bad++; $display("FAIL war_wrpend: got %h want 12", wr_pending); end
    // rd_done in WAIT_WR changes nothing; SA still owes r4
    rd_done = 3'b001; step(); rd_done = 3'b000; #1;
    total++; if (fu_busy !== 3'b011) begin bad++; $display("FAIL war_rd_ignored: got %b want 011", fu_busy); end
    drive(2'd2, 3'd0, 3'd0, 3'd4, 3'b001, 3'd0, 1'b0, 4'd9, 1'b0);
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL war_waitwr_raw: got %b want 0", issue_ready); end
    wr_done = 3'b011; step(); wr_done = 3'b000; #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL war_idle: got %b want 1", idle); end
    total++; if (wr_pending !== 8'h00) begin bad++; $display("FAIL war_clear: got %h want 00", wr_pending); end
    $display("war: done, busy=%b wrpend=%h", fu_busy, wr_pending);
  endtask

  task automatic test_dup_release();
    drive(2'd0, 3'd0, 3'd2, 3'd2, 3'b111, 3'd0, 1'b0, 4'd1, 1'b1);
    step();
    drive(2'd1, 3'd0, 3'd0, 3'd2, 3'b001, 3'd0, 1'b0, 4'd2, 1'b1);
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL dup_lsu_ready: got %b want 1", issue_ready); end
    step();
    // RF-write to r2 probes rd_cnt[2] through the WAR check
    drive(2'd2, 3'd0, 3'd0, 3'd0, 3'b000, 3'd2, 1'b1, 4'd3, 1'b0);
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL dup_war_r2: got %b want 0", issue_ready); end
    rd_done = 3'b011; step(); rd_done = 3'b000; #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL dup_rdcnt_zero: got %b want 1", issue_ready); end
    issue_rd = 3'd0; #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL dup_r0_free: got %b want 1", issue_ready); end
    total++; if (fu_busy !== 3'b011) begin bad++; $display("FAIL dup_waitwr: got %b want 011", fu_busy); end
    $display("dup: simultaneous rd_done cleared r2, busy=%b", fu_busy);
    wr_done = 3'b011; step(); wr_done = 3'b000; #1;
  endtask

  task automatic test_wr_no_rd();
    drive(2'd0, 3'd0, 3'd0, 3'd5, 3'b001, 3'd6, 1'b1, 4'd4, 1'b1);
    step();
    issue_valid = 1'b0;
    wr_done = 3'b001; step(); wr_done = 3'b000; #1;
    total++; if (fu_busy !== 3'b000) begin bad++; $display("FAIL wrnord_busy: got %b want 000", fu_busy); end
    total++; if (wr_pending !== 8'h00) begin bad++; $display("FAIL wrnord_wrpend: got %h want 00", wr_pending); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL wrnord_idle: got %b want 1", idle); end
    drive(2'd2, 3'd0, 3'd0, 3'd0, 3'b000, 3'd5, 1'b1, 4'd0, 1'b0);
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL wrnord_rdcnt: got %b want 1", issue_ready); end
    $display("wr_no_rd: slot freed, busy=%b wrpend=%h", fu_busy, wr_pending);
  endtask

  task automatic test_back_to_back();
    drive(2'd0, 3'd0, 3'd0, 3'd1, 3'b001, 3'd2, 1'b1, 4'd1, 1'b1);
    step();
    drive(2'd1, 3'd0, 3'd0, 3'd3, 3'b001, 3'd4, 1'b1, 4'd2, 1'b1);
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL b2b_lsu: got %b want 1", issue_ready); end
    step();
    drive(2'd2, 3'd0, 3'd0, 3'd5, 3'b001, 3'd6, 1'b1, 4'd3, 1'b1);
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL b2b_rfw: got %b want 1", issue_ready); end
    step();
    drive(2'd0, 3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 1'b0, 4'd0, 1'b0);
    total++; if (fu_busy !== 3'b111) begin bad++; $display("FAIL b2b_busy: got %b want 111", fu_busy); end
    total++; if (wr_pending !== 8'h54) begin bad++; $display("FAIL b2b_wrpend: got %h want 54", wr_pending); end
    total++; if (fu_id !== 12'h321) begin bad++; $display("FAIL b2b_ids: got %h want 321", fu_id); end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL b2b_fu_busy_block: got %b want 0", issue_ready); end
    $display("back_to_back: busy=%b wrpend=%h ids=%h", fu_busy, wr_pending, fu_id);
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (fu_busy !== 3'b000) begin bad++; $display("FAIL arst_busy: got %b want 000", fu_busy); end
    total++; if (wr_pending !== 8'h00) begin bad++; $display("FAIL arst_wrpend: got %h want 00", wr_pending); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL arst_idle: got %b want 1", idle); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL arst_ready: got %b want 1", issue_ready); end
    total++; if (fu_id !== 12'h000) begin bad++; $display("FAIL arst_id: got %h want 000", fu_id); end
    step();
    rst_n = 1'b1;
    rd_done = 3'b111; wr_done = 3'b111;
    step();
    rd_done = 3'b000; wr_done = 3'b000; #1;
    total++; if (fu_busy !== 3'b000) begin bad++; $display("FAIL arst_done_ignored: got %b want 000", fu_busy); end
    total++; if (wr_pending !== 8'h00) begin bad++; $display("FAIL arst_wrpend_after: got %h want 00", wr_pending); end
    $display("async_reset: busy=%b wrpend=%h idle=%b", fu_busy, wr_pending, idle);
  endtask

  initial begin
`ifdef QUADRILATERO_SB_BYPASS_EN
    bypass_en = 1'b1;
`else
    bypass_en = 1'b0;
`endif
    rst_n = 1'b0;
    test_reset();
    test_issue_basic();
    test_raw();
    test_war();
    test_dup_release();
    test_wr_no_rd();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
